// File: rtl/qam64_symbol_packer.sv
// qam64_symbol_packer: repacks FIFO bytes MSB-first into 6-bit 64-QAM
// symbols and maps each 3-bit axis index to a signed amplitude level.
module qam64_symbol_packer #(
  parameter bit GRAY_MAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_empty,
  input  logic [7:0] read_data,
  output logic       read_enable,
  input  logic       sym_ready,
  output logic       sym_valid,
  output logic [5:0] sym_data,
  output logic [3:0] i_level,
  output logic [3:0] q_level,
  output logic [3:0] bit_count,
  output logic       idle
);

  logic [13:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        inflight_q, inflight_d;
  logic        vld_q, vld_d;
  logic [5:0]  sym_q, sym_d;
  logic [3:0]  i_q, i_d;
  logic [3:0]  q_q, q_d;

  logic        ext;
  logic [13:0] acc_sh;
  logic [3:0]  cnt_sh;

  // 3-bit axis index to odd level 2*b-7; Gray input decoded to binary first
  function automatic logic [3:0] lvl(input logic [2:0] idx);
    logic [2:0] b;
    if (GRAY_MAP) begin
      b[2] = idx[2];
      b[1] = idx[2] ^ idx[1];
      b[0] = b[1] ^ idx[0];
    end else begin
      b = idx;
    end
    return {~b[2], b[1], b[0], 1'b1};
  endfunction

  // Read only while the accumulator can take a full byte
  assign read_enable = rst_n && !fifo_empty &&
                       (cnt_q < 4'd6) && !inflight_q;

  // Extract, then append the returning byte below the remaining bits
  always_comb begin
    ext        = (cnt_q >= 4'd6) && (!vld_q || sym_ready);
    acc_sh     = ext ? {acc_q[7:0], 6'b0} : acc_q;
    cnt_sh     = ext ? (cnt_q - 4'd6) : cnt_q;
    acc_d      = acc_sh;
    cnt_d      = cnt_sh;
    inflight_d = read_enable;
    vld_d      = vld_q;
    sym_d      = sym_q;
    i_d        = i_q;
    q_d        = q_q;
    if (inflight_q) begin
      acc_d = acc_sh | ({read_data, 6'b0} >> cnt_sh);
      cnt_d = cnt_sh + 4'd8;
    end
    if (ext) begin
      vld_d = 1'b1;
      sym_d = acc_q[13:8];
      i_d   = lvl(acc_q[13:11]);
      q_d   = lvl(acc_q[10:8]);
    end else if (sym_ready) begin
      vld_d = 1'b0;
    end
  end

  // State registers; reset drops all buffered bits and pending symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      vld_q      <= 1'b0;
      sym_q      <= '0;
      i_q        <= '0;
      q_q        <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
      sym_q      <= sym_d;
      i_q        <= i_d;
      q_q        <= q_d;
    end
  end

  assign sym_valid = vld_q;
  assign sym_data  = sym_q;
  assign i_level   = i_q;
  assign q_level   = q_q;
  assign bit_count = cnt_q;
  assign idle      = (cnt_q < 4'd6) && !inflight_q && !vld_q;

endmodule

// File: tb/tb_qam64_symbol_packer.sv
// tb_qam64_symbol_packer: directed bench for the 64-QAM symbol packer,
// Gray-mapped DUT plus a binary-mapped twin fed in lockstep.
module tb_qam64_symbol_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty;
  logic [7:0] read_data = 8'h00;
  logic       sym_ready = 1'b1;

  logic       read_enable, sym_valid, idle;
  logic [5:0] sym_data;
  logic [3:0] i_level, q_level, bit_count;

  logic       re_b, vld_b, idle_b;
  logic [5:0] sym_b;
  logic [3:0] i_b, q_b, cnt_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (read_enable) begin
      read_data <= mem[rd_ptr[4:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  qam64_symbol_packer #(.GRAY_MAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
    .read_data(read_data), .read_enable(read_enable),
    .sym_ready(sym_ready), .sym_valid(sym_valid),
    .sym_data(sym_data), .i_level(i_level), .q_level(q_level),
    .bit_count(bit_count), .idle(idle)
  );

  qam64_symbol_packer #(.GRAY_MAP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
    .read_data(read_data), .read_enable(re_b),
    .sym_ready(sym_ready), .sym_valid(vld_b),
    .sym_data(sym_b), .i_level(i_b), .q_level(q_b),
    .bit_count(cnt_b), .idle(idle_b)
  );

  task automatic chk(input string tag,
                     input logic signed [15:0] obs,
                     input logic signed [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[4:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Called at a negedge; waits for sym_valid, checks, stays at that negedge
  task automatic wait_sym(input string tag, input logic [5:0] d,
                          input int gi, input int gq,
                          input int bi, input int bq);
    int n;
    n = 0;
    while (!sym_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 16'(sym_valid), 16'sd1);
    chk({tag, "_data"}, 16'(sym_data), 16'(d));
    chk({tag, "_i"}, 16'($signed(i_level)), 16'(gi));
    chk({tag, "_q"}, 16'($signed(q_level)), 16'(gq));
    chk({tag, "_bi"}, 16'($signed(i_b)), 16'(bi));
    chk({tag, "_bq"}, 16'($signed(q_b)), 16'(bq));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with data waiting
    push(8'hFC); push(8'h0F); push(8'hC3);
    repeat (3) @(negedge clk);
    chk("rst_re", 16'(read_enable), 16'sd0);
    chk("rst_vld", 16'(sym_valid), 16'sd0);
    chk("rst_idle", 16'(idle), 16'sd1);
    chk("rst_cnt", 16'(bit_count), 16'sd0);
    chk("rst_sym", 16'(sym_data), 16'sd0);
    chk("rst_i", 16'(i_level), 16'sd0);
    chk("rst_q", 16'(q_level), 16'sd0);
    rst_n = 1'b1;
    #1;
    chk("first_re", 16'(read_enable), 16'sd1);
    @(negedge clk);

    // 2: packing with sym_ready=1
    wait_sym("p0", 6'h3F, 3, 3, 7, 7);
    @(negedge clk);
    wait_sym("p1", 6'h00, -7, -7, -7, -7);
    @(negedge clk);
    wait_sym("p2", 6'h3F, 3, 3, 7, 7);
    @(negedge clk);
    wait_sym("p3", 6'h03, -7, -3, -7, -1);
    @(negedge clk);
    chk("p_cnt", 16'(bit_count), 16'sd0);
    chk("p_vld", 16'(sym_valid), 16'sd0);

    // 3: backpressure
    sym_ready = 1'b0;
    push(8'hFC); push(8'h0F); push(8'hC3);
    wait_sym("b0", 6'h3F, 3, 3, 7, 7);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_vld", 16'(sym_valid), 16'sd1);
      chk("bp_hold", 16'(sym_data), 16'sh3F);
      checks++;
      assert (bit_count <= 4'd13) else begin
        errors++;
        $error("FAIL bp_cnt: got %0d expected <= 13", bit_count);
      end
      if (bit_count >= 4'd6)
        chk("bp_noread", 16'(read_enable), 16'sd0);
    end
    chk("bp_cnt10", 16'(bit_count), 16'sd10);
    sym_ready = 1'b1;
    wait_sym("b0r", 6'h3F, 3, 3, 7, 7);
    @(negedge clk);
    wait_sym("b1", 6'h00, -7, -7, -7, -7);
    @(negedge clk);
    wait_sym("b2", 6'h3F, 3, 3, 7, 7);
    @(negedge clk);
    wait_sym("b3", 6'h03, -7, -3, -7, -1);
    @(negedge clk);
    chk("b_cnt", 16'(bit_count), 16'sd0);

    // 4: residual bits
    push(8'hA5);
    wait_sym("r0", 6'h29, 5, -5, 3, -5);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("r_noread", 16'(read_enable), 16'sd0);
      chk("r_novld", 16'(sym_valid), 16'sd0);
      @(negedge clk);
    end
    chk("r_cnt", 16'(bit_count), 16'sd2);
    chk("r_idle", 16'(idle), 16'sd1);

    // 6: reset mid-stream (bit_count=4, symbol pending)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push(8'hFC); push(8'h0F);
    wait_sym("m0", 6'h3F, 3, 3, 7, 7);
    @(negedge clk);
    sym_ready = 1'b0;
    wait_sym("m1", 6'h00, -7, -7, -7, -7);
    chk("m_cnt4", 16'(bit_count), 16'sd4);
    rst_n = 1'b0;
    #1;
    chk("mr_vld", 16'(sym_valid), 16'sd0);
    chk("mr_sym", 16'(sym_data), 16'sd0);
    chk("mr_i", 16'(i_level), 16'sd0);
    chk("mr_q", 16'(q_level), 16'sd0);
    chk("mr_cnt", 16'(bit_count), 16'sd0);
    chk("mr_idle", 16'(idle), 16'sd1);
    chk("mr_re", 16'(read_enable), 16'sd0);
    push(8'h81);
    @(negedge clk);
    sym_ready = 1'b1;
    rst_n = 1'b1;
    wait_sym("n0", 6'h20, 7, -7, 1, -7);
    @(negedge clk);
    chk("n_cnt", 16'(bit_count), 16'sd2);
    chk("n_vld", 16'(sym_valid), 16'sd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
